// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants used by the EX/MEM boundary.
package cpu_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [4:0]  XZR        = 5'd31;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-side handshake and payload bundle between the EX stage / hazard unit
// (master) and the EX/MEM pipeline register (slave).
interface ex_mem_reg_if #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) ();

  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_result;
  logic                  ex_negative;
  logic                  ex_zero;
  logic                  ex_overflow;
  logic                  ex_carry_out;
  logic                  ex_set_flags;
  logic [DATA_W-1:0]     ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  stall;
  logic                  flush;
  logic                  ex_ready;

  modport master (
    output ex_valid, ex_result, ex_negative, ex_zero, ex_overflow, ex_carry_out,
           ex_set_flags, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, stall, flush,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_result, ex_negative, ex_zero, ex_overflow, ex_carry_out,
           ex_set_flags, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, stall, flush,
    output ex_ready
  );

endinterface

// File: rtl/ex_mem_reg_flag_reg.sv
// Architectural NZVC register with load enable. Define FLAG_BYPASS_EN to
// forward an in-flight flag setter straight to the B.cond view.
import cpu_pkg::*;

module flag_reg (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bypass_sel,
  input  flags_t d,
  output flags_t q,
  output flags_t cond
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

`ifdef FLAG_BYPASS_EN
  // Bypass ignores stall so B.cond can resolve in the same cycle as the setter.
  assign cond = bypass_sel ? d : q;
`else
  logic unused_bypass_sel;
  assign unused_bypass_sel = bypass_sel;
  assign cond = q;
`endif

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: payload/control capture, NZVC flag ownership and
// saturating stall counter. Optional flag bypass via FLAG_BYPASS_EN.
import cpu_pkg::*;

module ex_mem_reg #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ex_mem_reg_if.slave           ex,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_result,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [3:0]            flags_q,
  output logic [3:0]            flags_cond,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic         accept;
  logic         live;
  ex_mem_ctrl_t ctrl_q;
  flags_t       ex_flags;
  flags_t       flags_reg_q;
  flags_t       flags_reg_cond;

  assign accept      = !ex.stall;
  assign live        = ex.ex_valid & !ex.flush;
  assign ex.ex_ready = accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      ctrl_q         <= '0;
    end else if (accept) begin
      mem_valid         <= live;
      mem_result        <= ex.ex_result;
      mem_store_data    <= ex.ex_store_data;
      mem_rd            <= ex.ex_rd;
      ctrl_q.reg_write  <= ex.ex_reg_write & live & (ex.ex_rd != REG_ADDR_W'(XZR));
      ctrl_q.mem_read   <= ex.ex_mem_read & live;
      ctrl_q.mem_write  <= ex.ex_mem_write & live;
    end
  end

  assign mem_reg_write = ctrl_q.reg_write;
  assign mem_mem_read  = ctrl_q.mem_read;
  assign mem_mem_write = ctrl_q.mem_write;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (ex.stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

  assign ex_flags = '{n: ex.ex_negative, z: ex.ex_zero,
                      v: ex.ex_overflow, c: ex.ex_carry_out};

  flag_reg u_flag_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (live & ex.ex_set_flags & accept),
    .bypass_sel (live & ex.ex_set_flags),
    .d          (ex_flags),
    .q          (flags_reg_q),
    .cond       (flags_reg_cond)
  );

  assign flags_q    = flags_reg_q;
  assign flags_cond = flags_reg_cond;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg; flag-bypass expectations follow FLAG_BYPASS_EN.
module tb_ex_mem_reg;
  import cpu_pkg::*;

  localparam int unsigned CNT_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_valid;
  logic [63:0]       mem_result;
  logic [63:0]       mem_store_data;
  logic [4:0]        mem_rd;
  logic              mem_reg_write;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic [3:0]        flags_q;
  logic [3:0]        flags_cond;
  logic [CNT_W-1:0]  stall_cycles;

  int vectors = 0;
  int errors  = 0;

  ex_mem_reg_if #(.DATA_W(64), .REG_ADDR_W(5)) bus ();

  ex_mem_reg #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex             (bus),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .flags_q        (flags_q),
    .flags_cond     (flags_cond),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.ex_valid = 0; bus.ex_result = '0; bus.ex_negative = 0; bus.ex_zero = 0;
    bus.ex_overflow = 0; bus.ex_carry_out = 0; bus.ex_set_flags = 0;
    bus.ex_store_data = '0; bus.ex_rd = '0; bus.ex_reg_write = 0;
    bus.ex_mem_read = 0; bus.ex_mem_write = 0; bus.stall = 0; bus.flush = 0;
  endtask

  task automatic set_instr(input logic [63:0] res, input logic [3:0] nzvc,
                           input logic sf, input logic [63:0] sd, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw);
    bus.ex_valid = 1; bus.ex_result = res;
    {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out} = nzvc;
    bus.ex_set_flags = sf; bus.ex_store_data = sd; bus.ex_rd = rd;
    bus.ex_reg_write = rw; bus.ex_mem_read = mr; bus.ex_mem_write = mw;
  endtask

  task automatic test_reset;
    bus.ex_valid = 1'($urandom); bus.ex_result = {$urandom, $urandom};
    {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out} = 4'($urandom);
    bus.ex_set_flags = 1; bus.ex_store_data = {$urandom, $urandom};
    bus.ex_rd = 5'($urandom); bus.ex_reg_write = 1; bus.ex_mem_read = 1;
    bus.ex_mem_write = 1; bus.stall = 1'($urandom); bus.flush = 1'($urandom);
    reset = 1;
    tick; tick;
    vectors++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", mem_valid); end
    vectors++; if (mem_result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", mem_result); end
    vectors++; if (mem_store_data !== 64'h0) begin errors++; $display("FAIL reset_sdata got=%h exp=0", mem_store_data); end
    vectors++; if (mem_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", mem_rd); end
    vectors++; if ({mem_reg_write, mem_mem_read, mem_mem_write} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl got=%b exp=000", {mem_reg_write, mem_mem_read, mem_mem_write}); end
    vectors++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
    vectors++; if (stall_cycles !== 3'd0) begin errors++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_cycles); end
    clear_inputs;
    reset = 0;
    #1;
    vectors++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got=%b exp=1", bus.ex_ready); end
    tick;
    vectors++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble got=%b exp=0", mem_valid); end
  endtask

  task automatic test_adds;
    set_instr(64'h0, 4'b0101, 1, 64'h55, 5'd3, 1, 0, 0);
    tick;
    vectors++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL adds_valid got=%b exp=1", mem_valid); end
    vectors++; if (mem_result !== 64'h0) begin errors++; $display("FAIL adds_result got=%h exp=0", mem_result); end
    vectors++; if (mem_rd !== 5'd3) begin errors++; $display("FAIL adds_rd got=%0d exp=3", mem_rd); end
    vectors++; if (mem_reg_write !== 1'b1) begin errors++; $display("FAIL adds_rw got=%b exp=1", mem_reg_write); end
    vectors++; if (mem_store_data !== 64'h55) begin errors++; $display("FAIL adds_sdata got=%h exp=55", mem_store_data); end
    vectors++; if (flags_q !== 4'b0101) begin errors++; $display("FAIL adds_flags got=%b exp=0101", flags_q); end
  endtask

  task automatic test_xzr;
    set_instr(64'h1234, 4'b1010, 0, 64'h0, 5'd31, 1, 0, 0);
    tick;
    vectors++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL xzr_valid got=%b exp=1", mem_valid); end
    vectors++; if (mem_reg_write !== 1'b0) begin errors++; $display("FAIL xzr_rw got=%b exp=0", mem_reg_write); end
    vectors++; if (mem_result !== 64'h1234) begin errors++; $display("FAIL xzr_result got=%h exp=1234", mem_result); end
    vectors++; if (flags_q !== 4'b0101) begin errors++; $display("FAIL xzr_flags got=%b exp=0101", flags_q); end
    set_instr(64'h0F0F, 4'b1000, 0, 64'h0, 5'd7, 1, 0, 0);
    tick;
    vectors++; if (mem_reg_write !== 1'b1 || mem_rd !== 5'd7) begin errors++;
      $display("FAIL and_rw got=%b/%0d exp=1/7", mem_reg_write, mem_rd); end
    vectors++; if (flags_q !== 4'b0101) begin errors++; $display("FAIL and_flags got=%b exp=0101", flags_q); end
  endtask

  task automatic test_stall;
    logic [3:0] exp_cond;
    set_instr(64'hAAAA, 4'b1000, 1, 64'h77, 5'd9, 1, 0, 0);
    bus.stall = 1;
    #1;
    vectors++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", bus.ex_ready); end
`ifdef FLAG_BYPASS_EN
    exp_cond = 4'b1000;
`else
    exp_cond = 4'b0101;
`endif
    vectors++; if (flags_cond !== exp_cond) begin errors++; $display("FAIL stall_cond got=%b exp=%b", flags_cond, exp_cond); end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++; if (mem_result !== 64'h0F0F || mem_rd !== 5'd7 || flags_q !== 4'b0101) begin errors++;
        $display("FAIL stall_hold%0d got=%h/%0d/%b exp=0f0f/7/0101", i, mem_result, mem_rd, flags_q); end
    end
    vectors++; if (stall_cycles !== 3'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", stall_cycles); end
    bus.stall = 0;
    tick;
    vectors++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL release_flags got=%b exp=1000", flags_q); end
    vectors++; if (mem_result !== 64'hAAAA || mem_rd !== 5'd9) begin errors++;
      $display("FAIL release_data got=%h/%0d exp=aaaa/9", mem_result, mem_rd); end
    vectors++; if (stall_cycles !== 3'd3) begin errors++; $display("FAIL release_cnt got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_flush;
    set_instr(64'hBEEF, 4'b0100, 1, 64'h99, 5'd5, 1, 0, 1);
    bus.flush = 1;
    #1;
    vectors++; if (flags_cond !== 4'b1000) begin errors++; $display("FAIL flush_cond got=%b exp=1000", flags_cond); end
    tick;
    vectors++; if ({mem_valid, mem_reg_write, mem_mem_write} !== 3'b000) begin errors++;
      $display("FAIL flush_bubble got=%b exp=000", {mem_valid, mem_reg_write, mem_mem_write}); end
    vectors++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL flush_flags got=%b exp=1000", flags_q); end
    bus.flush = 0;
    set_instr(64'h100, 4'b0000, 0, 64'hDEAD, 5'd4, 0, 0, 1);
    tick;
    vectors++; if (mem_valid !== 1'b1 || mem_mem_write !== 1'b1 || mem_store_data !== 64'hDEAD) begin errors++;
      $display("FAIL stur got=%b/%b/%h exp=1/1/dead", mem_valid, mem_mem_write, mem_store_data); end
    set_instr(64'hBEEF, 4'b0100, 1, 64'h0, 5'd5, 1, 1, 0);
    bus.flush = 1;
    bus.stall = 1;
    tick; tick;
    vectors++; if ({mem_valid, mem_mem_read, mem_mem_write} !== 3'b101 || mem_result !== 64'h100) begin errors++;
      $display("FAIL flush_stall_hold got=%b/%h exp=101/100", {mem_valid, mem_mem_read, mem_mem_write}, mem_result); end
    vectors++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL flush_stall_flags got=%b exp=1000", flags_q); end
    vectors++; if (stall_cycles !== 3'd5) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=5", stall_cycles); end
  endtask

  task automatic test_saturation;
    bus.flush = 0;
    bus.stall = 1;
    tick; tick;
    vectors++; if (stall_cycles !== 3'd7) begin errors++; $display("FAIL sat_reach got=%0d exp=7", stall_cycles); end
    tick; tick; tick;
    vectors++; if (stall_cycles !== 3'd7) begin errors++; $display("FAIL sat_hold got=%0d exp=7", stall_cycles); end
    vectors++; if (mem_result !== 64'h100 || flags_q !== 4'b1000) begin errors++;
      $display("FAIL sat_data got=%h/%b exp=100/1000", mem_result, flags_q); end
    bus.stall = 0;
  endtask

  task automatic test_bypass;
    logic [3:0] exp_cond;
    set_instr(64'h0, 4'b0100, 1, 64'h0, 5'd2, 1, 0, 0);
    #1;
`ifdef FLAG_BYPASS_EN
    exp_cond = 4'b0100;
`else
    exp_cond = 4'b1000;
`endif
    vectors++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL byp_flags_q got=%b exp=1000", flags_q); end
    vectors++; if (flags_cond !== exp_cond) begin errors++; $display("FAIL byp_cond got=%b exp=%b", flags_cond, exp_cond); end
    bus.ex_valid = 0;
    #1;
    vectors++; if (flags_cond !== 4'b1000) begin errors++; $display("FAIL byp_invalid got=%b exp=1000", flags_cond); end
    bus.ex_valid = 1;
    tick;
    vectors++; if (flags_q !== 4'b0100 || flags_cond !== 4'b0100) begin errors++;
      $display("FAIL byp_commit got=%b/%b exp=0100/0100", flags_q, flags_cond); end
  endtask

  task automatic test_back_to_back;
    set_instr(64'h1, 4'b0011, 1, 64'h0, 5'd1, 1, 0, 0);
    tick;
    vectors++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL b2b_first got=%b exp=0011", flags_q); end
    set_instr(64'h2, 4'b1001, 1, 64'h0, 5'd2, 1, 0, 0);
    tick;
    vectors++; if (flags_q !== 4'b1001) begin errors++; $display("FAIL b2b_second got=%b exp=1001", flags_q); end
    set_instr(64'h3, 4'b1111, 1, 64'h0, 5'd3, 1, 1, 1);
    bus.ex_valid = 0;
    tick;
    vectors++; if (flags_q !== 4'b1001) begin errors++; $display("FAIL b2b_bubble_flags got=%b exp=1001", flags_q); end
    vectors++; if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write} !== 4'b0000) begin errors++;
      $display("FAIL b2b_bubble_ctrl got=%b exp=0000", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write}); end
  endtask

  task automatic test_reset_mid_stall;
    set_instr(64'h321, 4'b1111, 1, 64'h0, 5'd6, 1, 1, 0);
    tick;
    vectors++; if (mem_mem_read !== 1'b1 || flags_q !== 4'b1111) begin errors++;
      $display("FAIL pre_reset got=%b/%b exp=1/1111", mem_mem_read, flags_q); end
    bus.stall = 1;
    tick;
    reset = 1;
    tick;
    vectors++; if ({mem_valid, mem_mem_read, mem_reg_write} !== 3'b000 || mem_result !== 64'h0) begin errors++;
      $display("FAIL midstall_reset got=%b/%h exp=000/0", {mem_valid, mem_mem_read, mem_reg_write}, mem_result); end
    vectors++; if (flags_q !== 4'b0000 || stall_cycles !== 3'd0) begin errors++;
      $display("FAIL midstall_reset_st got=%b/%0d exp=0000/0", flags_q, stall_cycles); end
    reset = 0;
    clear_inputs;
  endtask

  initial begin
    reset = 1;
    clear_inputs;
    test_reset;
    test_adds;
    test_xzr;
    test_stall;
    test_flush;
    test_saturation;
    test_bypass;
    test_back_to_back;
    test_reset_mid_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
EX/MEM pipeline boundary of the 64-bit pipelined CPU. It sits directly downstream of the ALU.
- Registers the ALU result, store data and control fields for the MEM stage.
- Owns the architectural NZVC flag register, updated by flag-setting instructions (ADDS/SUBS/ANDS).
- Provides the current flags to the B.cond evaluation logic.
- Handles the stall/flush handshake with the hazard unit and counts stall cycles.

Parameters:
DATA_W, 64, datapath width
REG_ADDR_W, 5, register index width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  EX stage holds a real instruction
ex_result  in  DATA_W  ALU result
ex_negative  in  1  ALU negative flag
ex_zero  in  1  ALU zero flag
ex_overflow  in  1  ALU overflow
ex_carry_out  in  1  ALU carry out
ex_set_flags  in  1  instruction writes NZVC
ex_store_data  in  DATA_W  Rt value for STUR
ex_rd  in  REG_ADDR_W  destination register
ex_reg_write  in  1  writes register file
ex_mem_read  in  1  load
ex_mem_write  in  1  store
stall  in  1  MEM not accepting; hold register
flush  in  1  kill instruction currently in EX
ex_ready  out  1  EX result accepted this cycle
mem_valid  out  1  MEM-stage instruction valid
mem_result  out  DATA_W  registered ALU result / address
mem_store_data  out  DATA_W  registered store data
mem_rd  out  REG_ADDR_W  registered destination
mem_reg_write  out  1  registered, qualified write enable
mem_mem_read  out  1  registered load enable
mem_mem_write  out  1  registered store enable
flags_q  out  4  architectural {N,Z,V,C}
flags_cond  out  4  flags seen by B.cond logic
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset, synchronous: all mem_* outputs are 0, mem_valid is 0, flags_q is 4'b0000 and stall_cycles is 0. Reset overrides stall and flush. Reset mid-stall discards the held instruction.
- ex_ready equals !stall, combinational.
- Accept occurs when stall=0. On the next edge:
  - mem_valid <= ex_valid & !flush.
  - The payload registers load the ex_* values.
  - mem_reg_write <= ex_reg_write & ex_valid & !flush & (ex_rd != 31). A write to XZR is suppressed.
  - mem_mem_read and mem_mem_write are qualified the same way, by valid & !flush.
- Latency is 1 cycle from EX to the mem_* outputs.
- Stall (stall=1): every mem_* register and flags_q hold their value. The EX instruction is not consumed, and upstream re-presents it.
- flush with stall=0: the EX instruction becomes a bubble (mem_valid=0, all enables 0). Payload data may load but is don't-care.
- flush with stall=1: no state change. The hazard unit keeps flush asserted until ex_ready=1.
- Flag update: flags_q <= {ex_negative, ex_zero, ex_overflow, ex_carry_out} only when ex_valid & ex_set_flags & !flush & !stall. Otherwise flags_q holds.
  - Non-flag-setting instructions, bubbles and flushed instructions never change the flags.
- stall_cycles increments on each cycle with stall=1 and saturates at all-ones. It is never cleared except by reset.
- Back-to-back flag setters: each accepted instruction updates flags_q in order. The last accepted one wins.

Optional Feature:
FLAG_BYPASS_EN
- Defined: flags_cond = {ex_negative, ex_zero, ex_overflow, ex_carry_out} when ex_valid & ex_set_flags & !flush; otherwise flags_cond = flags_q. The bypass is independent of stall. This lets B.cond directly follow ADDS/SUBS with no bubble.
- Undefined: flags_cond = flags_q, and the hazard unit must insert one stall after a flag setter.

Decomposition:
- Package cpu_pkg holds:
  - typedef flags_t as a packed struct {n, z, v, c}
  - constants DATA_W=64, REG_ADDR_W=5, XZR=5'd31
  - typedef ex_mem_ctrl_t {reg_write, mem_read, mem_write}
- One sub-module, flag_reg: a 4-bit register with synchronous reset, load enable and optional bypass mux. It is instantiated once.

Test Plan:
- Reset held 2 cycles with random inputs -> all mem_*=0, flags_q=0000, stall_cycles=0.
- ADDS with ex_result=0, ex_zero=1, ex_carry_out=1, rd=3, stall=0 -> next cycle mem_result=0, mem_rd=3, mem_reg_write=1, flags_q=0100 then 0101 per {N,Z,V,C}: exactly 4'b0101.
- ADD with rd=31, ex_reg_write=1 -> mem_valid=1, mem_reg_write=0. A subsequent AND (set_flags=0) -> flags_q unchanged.
- stall=1 for 3 cycles while EX holds SUBS (N=1) -> mem_* and flags_q frozen, stall_cycles=3. On release, captured next cycle with flags_q=1000.
- flush=1 with ex_valid=1, ex_set_flags=1, ex_mem_write=1 -> mem_valid=0, mem_mem_write=0, flags_q unchanged. Repeated with stall=1 -> no change.
- With FLAG_BYPASS_EN, SUBS (Z=1) in EX -> flags_cond=0100 the same cycle while flags_q is still the old value. Without the macro -> flags_cond equals flags_q.
